// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode values, flag bit positions and the sequencer FSM encoding.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDC = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_INC  = 4'd4;
  localparam logic [3:0] OP_DEC  = 4'd5;
  localparam logic [3:0] OP_AND  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ROR  = 4'd8;
  localparam logic [3:0] OP_ROL  = 4'd9;

  localparam int unsigned FLG_C   = 0;
  localparam int unsigned FLG_BRW = 1;
  localparam int unsigned FLG_Z   = 2;
  localparam int unsigned FLG_P   = 3;
  localparam int unsigned FLG_INV = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StDrive = 2'd1,
    StResp  = 2'd2
  } seq_state_e;

endpackage

// File: rtl/alu_op_sequencer.sv
// Command-side initiator for a combinational ALU: registers operands, waits a settle time,
// captures Y/flags into a response, and keeps an accumulator/carry for chained arithmetic.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int unsigned BUS_WIDTH     = 8,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned ERR_CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [3:0]           cmd_opcode,
  input  logic [BUS_WIDTH-1:0] cmd_a,
  input  logic [BUS_WIDTH-1:0] cmd_b,
  input  logic                 cmd_carry_in,
  input  logic                 cmd_use_acc,
  input  logic                 cmd_chain_c,
  output logic [3:0]           alu_opcode,
  output logic [BUS_WIDTH-1:0] alu_a,
  output logic [BUS_WIDTH-1:0] alu_b,
  output logic                 alu_carry_in,
  input  logic [BUS_WIDTH-1:0] alu_y,
  input  logic [4:0]           alu_flags,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [BUS_WIDTH-1:0] rsp_y,
  output logic [4:0]           rsp_flags,
  output logic [BUS_WIDTH-1:0] acc,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  seq_state_e           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [3:0]           alu_opcode_q, alu_opcode_d;
  logic [BUS_WIDTH-1:0] alu_a_q, alu_a_d;
  logic [BUS_WIDTH-1:0] alu_b_q, alu_b_d;
  logic                 alu_carry_in_q, alu_carry_in_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [BUS_WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic [4:0]           rsp_flags_q, rsp_flags_d;
  logic [BUS_WIDTH-1:0] acc_q, acc_d;
  logic                 carry_q, carry_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    alu_opcode_d   = alu_opcode_q;
    alu_a_d        = alu_a_q;
    alu_b_d        = alu_b_q;
    alu_carry_in_d = alu_carry_in_q;
    rsp_valid_d    = rsp_valid_q;
    rsp_y_d        = rsp_y_q;
    rsp_flags_d    = rsp_flags_q;
    acc_d          = acc_q;
    carry_d        = carry_q;
    err_count_d    = err_count_q;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          alu_opcode_d   = cmd_opcode;
          alu_a_d        = cmd_use_acc ? acc_q : cmd_a;
          alu_b_d        = cmd_b;
          alu_carry_in_d = cmd_chain_c ? carry_q : cmd_carry_in;
          cnt_d          = CntLoad;
          state_d        = StDrive;
        end
      end
      StDrive: begin
        if (cnt_q == '0) begin
          rsp_y_d     = alu_y;
          rsp_flags_d = alu_flags;
          rsp_valid_d = 1'b1;
          state_d     = StResp;
          // Invalid opcodes leave the chaining state untouched so a bad op can't corrupt a chain.
          if (!alu_flags[FLG_INV]) begin
            acc_d   = alu_y;
            carry_d = alu_flags[FLG_C];
          end else if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      cnt_q          <= '0;
      alu_opcode_q   <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_carry_in_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_y_q        <= '0;
      rsp_flags_q    <= '0;
      acc_q          <= '0;
      carry_q        <= 1'b0;
      err_count_q    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_a_q        <= alu_a_d;
      alu_b_q        <= alu_b_d;
      alu_carry_in_q <= alu_carry_in_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_y_q        <= rsp_y_d;
      rsp_flags_q    <= rsp_flags_d;
      acc_q          <= acc_d;
      carry_q        <= carry_d;
      err_count_q    <= err_count_d;
    end
  end

  assign cmd_ready    = (state_q == StIdle);
  assign alu_opcode   = alu_opcode_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign alu_carry_in = alu_carry_in_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_y        = rsp_y_q;
  assign rsp_flags    = rsp_flags_q;
  assign acc          = acc_q;
  assign err_count    = err_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural 8-bit ALU attached beside it.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int unsigned Bw = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [3:0]    cmd_opcode = '0;
  logic [Bw-1:0] cmd_a = '0;
  logic [Bw-1:0] cmd_b = '0;
  logic          cmd_carry_in = 1'b0;
  logic          cmd_use_acc = 1'b0;
  logic          cmd_chain_c = 1'b0;
  logic [3:0]    alu_opcode;
  logic [Bw-1:0] alu_a;
  logic [Bw-1:0] alu_b;
  logic          alu_carry_in;
  logic [Bw-1:0] alu_y;
  logic [4:0]    alu_flags;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [Bw-1:0] rsp_y;
  logic [4:0]    rsp_flags;
  logic [Bw-1:0] acc;
  logic [7:0]    err_count;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  // Returns {flags, y}; flags = {inv, parity, zero, borrow, carry}.
  function automatic logic [12:0] alu_model(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic cin);
    logic [8:0] s;
    logic [7:0] y;
    logic       c, brw, inv;
    s = '0; y = '0; c = 1'b0; brw = 1'b0; inv = 1'b0;
    case (op)
      OP_ADD:  begin s = {1'b0, a} + {1'b0, b}; y = s[7:0]; c = s[8]; end
      OP_ADDC: begin s = {1'b0, a} + {1'b0, b} + {8'd0, cin}; y = s[7:0]; c = s[8]; end
      OP_SUB:  begin y = a - b; brw = (a < b); end
      OP_INC:  begin s = {1'b0, a} + 9'd1; y = s[7:0]; c = s[8]; end
      OP_DEC:  begin y = a - 8'd1; brw = (a == 8'd0); end
      OP_AND:  y = a & b;
      OP_NOT:  y = ~a;
      OP_ROR:  begin y = {a[0], a[7:1]}; c = a[0]; end
      OP_ROL:  begin y = {a[6:0], a[7]}; c = a[7]; end
      default: inv = 1'b1;
    endcase
    return {inv, ^y, (y == 8'd0), brw, c, y};
  endfunction

  assign {alu_flags, alu_y} = alu_model(alu_opcode, alu_a, alu_b, alu_carry_in);

  alu_op_sequencer #(
    .BUS_WIDTH    (Bw),
    .SETTLE_CYCLES(1),
    .ERR_CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_carry_in(cmd_carry_in),
    .cmd_use_acc (cmd_use_acc),
    .cmd_chain_c (cmd_chain_c),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_carry_in(alu_carry_in),
    .alu_y       (alu_y),
    .alu_flags   (alu_flags),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_y       (rsp_y),
    .rsp_flags   (rsp_flags),
    .acc         (acc),
    .err_count   (err_count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic cin, input logic ua, input logic cc);
    cmd_opcode = op; cmd_a = a; cmd_b = b;
    cmd_carry_in = cin; cmd_use_acc = ua; cmd_chain_c = cc;
  endtask

  // Called at a negedge; returns at a negedge with the sequencer back in idle.
  task automatic run_op(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic cin, input logic ua, input logic cc,
                        output logic [7:0] y, output logic [4:0] fl, output int lat);
    int i;
    set_cmd(op, a, b, cin, ua, cc);
    cmd_valid = 1'b1;
    i = 0;
    while (!cmd_ready && i < 20) begin @(negedge clk); i++; end
    if (!cmd_ready) check("cmd_ready_timeout", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 20) begin @(negedge clk); lat++; end
    if (!rsp_valid) check("rsp_valid_timeout", rsp_valid, 1);
    y  = rsp_y;
    fl = rsp_flags;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  y;
    logic [4:0]  fl;
    int          lat;
    logic [12:0] exp;

    // Reset state
    #12;
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_acc", acc, 0);
    check("rst_err", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_cmd_ready", cmd_ready, 1);

    // ADD 2+5
    run_op(OP_ADD, 8'd2, 8'd5, 1'b0, 1'b0, 1'b0, y, fl, lat);
    check("add_lat", lat, 2);
    check("add_y", y, 7);
    check("add_flags", fl, 5'b01000);
    check("add_acc", acc, 7);

    // Chained add
    run_op(OP_ADDC, 8'd200, 8'd100, 1'b0, 1'b0, 1'b0, y, fl, lat);
    check("addc1_y", y, 44);
    check("addc1_c", fl[FLG_C], 1);
    run_op(OP_ADDC, 8'd0, 8'd0, 1'b0, 1'b1, 1'b1, y, fl, lat);
    check("addc2_y", y, 45);
    check("addc2_acc", acc, 45);

    // Invalid opcode
    run_op(4'd10, 8'd0, 8'd5, 1'b0, 1'b0, 1'b0, y, fl, lat);
    check("inv_flag", fl[FLG_INV], 1);
    check("inv_acc", acc, 45);
    check("inv_err", err_count, 1);

    // Back-pressure: response held while a new command waits
    set_cmd(OP_ADD, 8'd1, 8'd1, 1'b0, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    @(negedge clk);
    set_cmd(OP_ADD, 8'd3, 8'd4, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("bp_acc", acc, 2);
    for (int k = 0; k < 5; k++) begin
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_rsp_valid", rsp_valid, 1);
      check("bp_rsp_y", rsp_y, 2);
      check("bp_rsp_flags", rsp_flags, 5'b01000);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("bp_released", cmd_ready, 1);
    check("bp_rsp_dropped", rsp_valid, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("bp_next_accepted", cmd_ready, 0);
    @(negedge clk);
    check("bp_next_valid", rsp_valid, 1);
    check("bp_next_y", rsp_y, 7);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;

    // Opcode sweep against the ALU model
    for (int op = 1; op <= 9; op++) begin
      run_op(4'(op), 8'd2, 8'd5, 1'b1, 1'b0, 1'b0, y, fl, lat);
      exp = alu_model(4'(op), 8'd2, 8'd5, 1'b1);
      check($sformatf("sweep_y_op%0d", op), y, exp[7:0]);
      check($sformatf("sweep_fl_op%0d", op), fl, exp[12:8]);
    end

    // Saturating error counter
    for (int k = 0; k < 254; k++) run_op(4'd15, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, y, fl, lat);
    check("err_255", err_count, 255);
    run_op(4'd11, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, y, fl, lat);
    check("err_sat", err_count, 255);
    check("err_acc_kept", acc, 4);

    // Leave acc=1, carry=1 so reset effects are visible
    run_op(OP_ADD, 8'd255, 8'd2, 1'b0, 1'b0, 1'b0, y, fl, lat);
    check("pre_rst_y", y, 1);
    check("pre_rst_c", fl[FLG_C], 1);

    // Reset mid-DRIVE
    set_cmd(OP_ADD, 8'd9, 8'd9, 1'b0, 1'b0, 1'b0);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    check("drive_alu_a", alu_a, 9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a", alu_a, 0);
    check("mid_rst_alu_b", alu_b, 0);
    check("mid_rst_alu_op", alu_opcode, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_rsp_y", rsp_y, 0);
    check("mid_rst_acc", acc, 0);
    check("mid_rst_err", err_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_ready", cmd_ready, 1);
    @(negedge clk);
    @(negedge clk);
    check("post_rst_no_rsp", rsp_valid, 0);
    run_op(OP_ADDC, 8'd0, 8'd3, 1'b0, 1'b1, 1'b1, y, fl, lat);
    check("post_rst_chain_y", y, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
